// File: rtl/fb_swap_controller_if.sv
// Frame-store handshake between the video timing, the raycaster and the swap controller.
interface fb_swap_controller_if #(
   parameter int unsigned DROP_CNT_WIDTH = 8
);
   localparam int unsigned HCNT_W      = 11;
   localparam int unsigned VCNT_W      = 10;
   localparam int unsigned FRAME_CNT_W = 16;

   logic [HCNT_W-1:0]         hcount_in;
   logic [VCNT_W-1:0]         vcount_in;
   logic                      ray_valid_in;
   logic                      ray_last_pixel_in;
   logic                      ray_start_out;
   logic                      write_en_out;
   logic                      write_sel_out;
   logic                      swap_out;
   logic [FRAME_CNT_W-1:0]    frame_count_out;
   logic [DROP_CNT_WIDTH-1:0] drop_count_out;
   logic                      error_out;

   // Video timing / raycaster side
   modport master (
      output hcount_in, vcount_in, ray_valid_in, ray_last_pixel_in,
      input  ray_start_out, write_en_out, write_sel_out, swap_out,
             frame_count_out, drop_count_out, error_out
   );

   // Swap controller side
   modport slave (
      input  hcount_in, vcount_in, ray_valid_in, ray_last_pixel_in,
      output ray_start_out, write_en_out, write_sel_out, swap_out,
             frame_count_out, drop_count_out, error_out
   );
endinterface

// File: rtl/fb_swap_controller.sv
// Double-buffered frame store sequencer: starts ray frames, gates pixel writes,
// and swaps write/display buffers only at a video frame boundary after a full render.
module fb_swap_controller #(
   parameter int unsigned FULL_SCREEN_WIDTH  = 1280,
   parameter int unsigned FULL_SCREEN_HEIGHT = 720,
   parameter int unsigned DROP_CNT_WIDTH     = 8
) (
   input  logic                pixel_clk_in,
   input  logic                rst_in,
   fb_swap_controller_if.slave bus
);
   localparam int unsigned HCNT_W      = 11;
   localparam int unsigned VCNT_W      = 10;
   localparam int unsigned FRAME_CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RENDER    = 2'd1,
      S_DONE_WAIT = 2'd2,
      S_SWAP      = 2'd3
   } state_e;

   state_e                    state_q;
   logic                      ray_start_q;
   logic                      write_sel_q;
   logic                      swap_q;
   logic                      error_q;
   logic [FRAME_CNT_W-1:0]    frame_cnt_q;
   logic [FRAME_CNT_W-1:0]    frame_cnt_d;
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_d;

   logic frame_end;
   logic accept;
   logic last;

   // Last active pixel of the last active line marks the video frame boundary
   assign frame_end = (bus.hcount_in == HCNT_W'(FULL_SCREEN_WIDTH - 1)) &&
                      (bus.vcount_in == VCNT_W'(FULL_SCREEN_HEIGHT - 1));

   // Pixels are only accepted in RENDER once the start pulse has been issued
   assign accept = (state_q == S_RENDER) && !ray_start_q && bus.ray_valid_in;
   assign last   = accept && bus.ray_last_pixel_in;

   // Saturating drop count and wrapping frame count
   assign drop_cnt_d  = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + DROP_CNT_WIDTH'(1);
   assign frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);

   // State machine with registered outputs; reset abandons any frame in flight
   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         state_q     <= S_IDLE;
         ray_start_q <= 1'b0;
         write_sel_q <= 1'b0;
         swap_q      <= 1'b0;
         error_q     <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         ray_start_q <= 1'b0;
         swap_q      <= 1'b0;
         if (bus.ray_valid_in && !accept) begin
            error_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               state_q     <= S_RENDER;
               ray_start_q <= 1'b1;
            end
            S_RENDER: begin
               if (last) begin
                  if (frame_end) begin
                     state_q <= S_SWAP;
                     swap_q  <= 1'b1;
                  end else begin
                     state_q <= S_DONE_WAIT;
                  end
               end else if (frame_end) begin
                  drop_cnt_q <= drop_cnt_d;
               end
            end
            S_DONE_WAIT: begin
               if (frame_end) begin
                  state_q <= S_SWAP;
                  swap_q  <= 1'b1;
               end
            end
            S_SWAP: begin
               state_q     <= S_RENDER;
               write_sel_q <= ~write_sel_q;
               frame_cnt_q <= frame_cnt_d;
               ray_start_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Write enable is zero-latency so it lines up with the address/data going to the BRAM
   assign bus.write_en_out    = !rst_in && accept;
   assign bus.ray_start_out   = ray_start_q;
   assign bus.write_sel_out   = write_sel_q;
   assign bus.swap_out        = swap_q;
   assign bus.frame_count_out = frame_cnt_q;
   assign bus.drop_count_out  = drop_cnt_q;
   assign bus.error_out       = error_q;

endmodule

// File: tb/tb_fb_swap_controller.sv
// Directed bench for fb_swap_controller on a shrunken 8x4 screen.
module tb_fb_swap_controller;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fb_swap_controller_if #(.DROP_CNT_WIDTH(8)) bus ();

   fb_swap_controller #(
      .FULL_SCREEN_WIDTH (8),
      .FULL_SCREEN_HEIGHT(4),
      .DROP_CNT_WIDTH    (8)
   ) dut (
      .pixel_clk_in(clk),
      .rst_in      (rst),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [10:0] hc;
      logic [9:0]  vc;
      logic        v;
      logic        l;
      logic        e_start;
      logic        e_wen;
      logic        e_sel;
      logic        e_swap;
      logic [15:0] e_fc;
      logic [7:0]  e_dc;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input int h, input int vv, input logic v, input logic l,
                               input logic st, input logic we, input logic sel, input logic sw,
                               input int fc, input int dc, input logic er);
      vec_t t;
      t.rst = r; t.hc = 11'(h); t.vc = 10'(vv); t.v = v; t.l = l;
      t.e_start = st; t.e_wen = we; t.e_sel = sel; t.e_swap = sw;
      t.e_fc = 16'(fc); t.e_dc = 8'(dc); t.e_err = er;
      return t;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs just after the rising edge; outputs are sampled at the falling edge
   task automatic cyc(input logic r, input logic [10:0] h, input logic [9:0] vv, input logic v, input logic l);
      @(posedge clk);
      #1;
      rst = r;
      bus.hcount_in = h;
      bus.vcount_in = vv;
      bus.ray_valid_in = v;
      bus.ray_last_pixel_in = l;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, 11'd0, 10'd0, 1'b0, 1'b0);
   endtask

   task automatic fe();
      cyc(1'b0, 11'd7, 10'd3, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cyc(1'b1, 11'd0, 10'd0, 1'b0, 1'b0);
      cyc(1'b1, 11'd0, 10'd0, 1'b0, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.hcount_in = '0;
      bus.vcount_in = '0;
      bus.ray_valid_in = 1'b0;
      bus.ray_last_pixel_in = 1'b0;
      do_reset();

      // Reset, release, one 10-pixel frame (with a stray last and near-miss frame_end), swap
      //                 rst h  v  val lst  start wen sel swap fc dc err
      tbl.push_back(mk(1, 0, 0, 1, 0,    0,   0,  0,  0,   0, 0, 0)); // valid during reset
      tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0,  0,  0,   0, 0, 0)); // IDLE
      tbl.push_back(mk(0, 0, 0, 0, 0,    1,   0,  0,  0,   0, 0, 0)); // start pulse
      tbl.push_back(mk(0, 0, 0, 1, 0,    0,   1,  0,  0,   0, 0, 0)); // px1
      tbl.push_back(mk(0, 7, 0, 1, 0,    0,   1,  0,  0,   0, 0, 0)); // px2, last column only
      tbl.push_back(mk(0, 0, 3, 1, 0,    0,   1,  0,  0,   0, 0, 0)); // px3, last line only
      tbl.push_back(mk(0, 0, 0, 1, 0,    0,   1,  0,  0,   0, 0, 0)); // px4
      tbl.push_back(mk(0, 0, 0, 0, 1,    0,   0,  0,  0,   0, 0, 0)); // last without valid
      tbl.push_back(mk(0, 0, 0, 1, 0,    0,   1,  0,  0,   0, 0, 0)); // px5
      tbl.push_back(mk(0, 0, 0, 1, 0,    0,   1,  0,  0,   0, 0, 0)); // px6
      tbl.push_back(mk(0, 0, 0, 1, 0,    0,   1,  0,  0,   0, 0, 0)); // px7
      tbl.push_back(mk(0, 0, 0, 1, 0,    0,   1,  0,  0,   0, 0, 0)); // px8
      tbl.push_back(mk(0, 0, 0, 1, 0,    0,   1,  0,  0,   0, 0, 0)); // px9
      tbl.push_back(mk(0, 0, 0, 1, 1,    0,   1,  0,  0,   0, 0, 0)); // px10 last
      tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0,  0,  0,   0, 0, 0)); // DONE_WAIT
      tbl.push_back(mk(0, 7, 3, 0, 0,    0,   0,  0,  0,   0, 0, 0)); // frame_end (T)
      tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0,  0,  1,   0, 0, 0)); // T+1 SWAP
      tbl.push_back(mk(0, 0, 0, 0, 0,    1,   0,  1,  0,   1, 0, 0)); // T+2 toggled, start
      tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0,  1,  0,   1, 0, 0)); // RENDER

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].rst, tbl[i].hc, tbl[i].vc, tbl[i].v, tbl[i].l);
         check($sformatf("row%0d.start", i), 32'(bus.ray_start_out),   32'(tbl[i].e_start));
         check($sformatf("row%0d.wen", i),   32'(bus.write_en_out),    32'(tbl[i].e_wen));
         check($sformatf("row%0d.sel", i),   32'(bus.write_sel_out),   32'(tbl[i].e_sel));
         check($sformatf("row%0d.swap", i),  32'(bus.swap_out),        32'(tbl[i].e_swap));
         check($sformatf("row%0d.fc", i),    32'(bus.frame_count_out), 32'(tbl[i].e_fc));
         check($sformatf("row%0d.dc", i),    32'(bus.drop_count_out),  32'(tbl[i].e_dc));
         check($sformatf("row%0d.err", i),   32'(bus.error_out),       32'(tbl[i].e_err));
      end

      // Three missed frame ends, then a late last waits for the next frame end
      do_reset();
      idle();
      idle();
      check("A.start", 32'(bus.ray_start_out), 32'd1);
      for (int k = 0; k < 3; k++) begin
         idle();
         fe();
      end
      idle();
      check("A.drops", 32'(bus.drop_count_out), 32'd3);
      cyc(1'b0, 11'd0, 10'd0, 1'b1, 1'b1);
      check("A.last_wen", 32'(bus.write_en_out), 32'd1);
      idle();
      check("A.wait_noswap", 32'(bus.swap_out), 32'd0);
      idle();
      fe();
      check("A.fe_noswap", 32'(bus.swap_out), 32'd0);
      idle();
      check("A.swap", 32'(bus.swap_out), 32'd1);
      idle();
      check("A.fc", 32'(bus.frame_count_out), 32'd1);
      check("A.sel", 32'(bus.write_sel_out), 32'd1);
      check("A.restart", 32'(bus.ray_start_out), 32'd1);
      check("A.dc_hold", 32'(bus.drop_count_out), 32'd3);

      // Last pixel coincides with frame end
      idle();
      cyc(1'b0, 11'd7, 10'd3, 1'b1, 1'b1);
      check("B.wen", 32'(bus.write_en_out), 32'd1);
      idle();
      check("B.swap", 32'(bus.swap_out), 32'd1);
      check("B.nodrop", 32'(bus.drop_count_out), 32'd3);
      idle();
      check("B.fc", 32'(bus.frame_count_out), 32'd2);
      check("B.sel", 32'(bus.write_sel_out), 32'd0);

      // Valid while waiting for the frame end is blocked and flagged
      idle();
      cyc(1'b0, 11'd0, 10'd0, 1'b1, 1'b1);
      cyc(1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
      check("C.wen_blocked", 32'(bus.write_en_out), 32'd0);
      idle();
      check("C.err", 32'(bus.error_out), 32'd1);
      fe();
      idle();
      idle();
      check("C.sticky", 32'(bus.error_out), 32'd1);
      check("C.fc", 32'(bus.frame_count_out), 32'd3);

      // Five quick frames, then reset mid-render
      do_reset();
      idle();
      idle();
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 11'd7, 10'd3, 1'b1, 1'b1);
         idle();
         idle();
      end
      check("D.fc5", 32'(bus.frame_count_out), 32'd5);
      check("D.sel1", 32'(bus.write_sel_out), 32'd1);
      idle();
      cyc(1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
      check("D.midwen", 32'(bus.write_en_out), 32'd1);
      cyc(1'b1, 11'd0, 10'd0, 1'b1, 1'b0);
      check("D.rst_wen", 32'(bus.write_en_out), 32'd0);
      idle();
      check("D.sel0", 32'(bus.write_sel_out), 32'd0);
      check("D.fc0", 32'(bus.frame_count_out), 32'd0);
      check("D.dc0", 32'(bus.drop_count_out), 32'd0);
      check("D.err0", 32'(bus.error_out), 32'd0);
      check("D.idle_nostart", 32'(bus.ray_start_out), 32'd0);
      idle();
      check("D.restart", 32'(bus.ray_start_out), 32'd1);

      // 300 consecutive drops saturate the counter
      idle();
      for (int i = 1; i <= 300; i++) begin
         fe();
         if (i == 255) check("E.dc254", 32'(bus.drop_count_out), 32'd254);
         if (i == 256) check("E.dc255", 32'(bus.drop_count_out), 32'd255);
      end
      idle();
      check("E.sat", 32'(bus.drop_count_out), 32'd255);
      check("E.nofc", 32'(bus.frame_count_out), 32'd0);

      // Valid during IDLE
      do_reset();
      cyc(1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
      check("F.idle_wen", 32'(bus.write_en_out), 32'd0);
      idle();
      check("F.idle_err", 32'(bus.error_out), 32'd1);

      // Valid during the SWAP cycle
      do_reset();
      idle();
      idle();
      cyc(1'b0, 11'd7, 10'd3, 1'b1, 1'b1);
      cyc(1'b0, 11'd0, 10'd0, 1'b1, 1'b1);
      check("G.swap", 32'(bus.swap_out), 32'd1);
      check("G.swap_wen", 32'(bus.write_en_out), 32'd0);
      idle();
      check("G.swap_err", 32'(bus.error_out), 32'd1);
      check("G.fc", 32'(bus.frame_count_out), 32'd1);

      // Valid during the start pulse cycle
      do_reset();
      idle();
      cyc(1'b0, 11'd0, 10'd0, 1'b1, 1'b0);
      check("H.start", 32'(bus.ray_start_out), 32'd1);
      idle();
      check("H.start_err", 32'(bus.error_out), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
